// File: rtl/bpred_history_table.sv
// Two-level branch predictor front half: global history register plus a table of
// 2-bit saturating counters, read combinationally and trained from resolved branches.
module bpred_history_table #(
    parameter int         HIST_BITS = 2,
    parameter logic [1:0] INIT_CTR  = 2'b00
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 lookup_valid,
    output logic [1:0]           sat_counter_2bit,
    output logic [HIST_BITS-1:0] lookup_index,
    input  logic                 upd_valid,
    input  logic [HIST_BITS-1:0] upd_index,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic [HIST_BITS-1:0] arch_bhr
);
    localparam int DEPTH = 1 << HIST_BITS;

    logic [HIST_BITS-1:0] specBhr;
    logic [HIST_BITS-1:0] archNext;
    logic [HIST_BITS-1:0] specShifted;
    logic [1:0]           bpt [DEPTH];
    logic [1:0]           curCtr;
    logic [1:0]           updCtr;
    logic                 predTaken;
    logic                 repair;

    assign sat_counter_2bit = bpt[specBhr];
    assign lookup_index     = specBhr;
    assign predTaken        = sat_counter_2bit[1];
    assign repair           = upd_valid & upd_mispredict;

    // Newest outcome always lands in bit 0; a 1-bit history is just the last outcome.
    generate
        if (HIST_BITS == 1) begin : gNarrow
            assign archNext    = upd_taken;
            assign specShifted = predTaken;
        end else begin : gWide
            assign archNext    = {arch_bhr[HIST_BITS-2:0], upd_taken};
            assign specShifted = {specBhr[HIST_BITS-2:0], predTaken};
        end
    endgenerate

    always_comb begin
        curCtr = bpt[upd_index];
        updCtr = curCtr;
        if (upd_taken) begin
            if (curCtr != 2'd3) updCtr = curCtr + 2'd1;
        end else begin
            if (curCtr != 2'd0) updCtr = curCtr - 2'd1;
        end
    end

    // No write-to-read bypass: a same-cycle lookup sees the old counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            specBhr  <= '0;
            arch_bhr <= '0;
            for (int i = 0; i < DEPTH; i++) bpt[i] <= INIT_CTR;
        end else begin
            if (upd_valid) begin
                bpt[upd_index] <= updCtr;
                arch_bhr       <= archNext;
            end
            if (repair)
                specBhr <= archNext;
            else if (lookup_valid && !stall)
                specBhr <= specShifted;
        end
    end
endmodule

// File: tb/tb_bpred_history_table.sv
// Drives a 2-bit-history and a 1-bit-history instance with directed and random
// traffic; an array-based model of the predictor rules supplies every expectation.
module tb_bpred_history_table;
    logic       clock = 1'b0;
    logic       reset, stall, lookupValid, updValid, updTaken, updMispredict;
    logic [1:0] updIndex;
    logic [1:0] sat2, idx2, arch2;
    logic [1:0] sat1;
    logic [0:0] idx1, arch1;

    int nChecks = 0;
    int nFails  = 0;

    // Model state: instance 0 has 4 entries, instance 1 has 2.
    int  mSpec [2];
    int  mArch [2];
    int  mBpt  [2][4];
    int  mDepth[2] = '{4, 2};
    bit  modelValid = 1'b0;

    always #5 clock = ~clock;

    bpred_history_table #(.HIST_BITS(2), .INIT_CTR(2'b00)) dut2 (
        .clock(clock), .reset(reset), .stall(stall), .lookup_valid(lookupValid),
        .sat_counter_2bit(sat2), .lookup_index(idx2),
        .upd_valid(updValid), .upd_index(updIndex), .upd_taken(updTaken),
        .upd_mispredict(updMispredict), .arch_bhr(arch2)
    );

    bpred_history_table #(.HIST_BITS(1), .INIT_CTR(2'b00)) dut1 (
        .clock(clock), .reset(reset), .stall(stall), .lookup_valid(lookupValid),
        .sat_counter_2bit(sat1), .lookup_index(idx1),
        .upd_valid(updValid), .upd_index(updIndex[0:0]), .upd_taken(updTaken),
        .upd_mispredict(updMispredict), .arch_bhr(arch1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkOuts();
        if (modelValid) begin
            chk("h2_sat",  int'(sat2),  mBpt[0][mSpec[0]]);
            chk("h2_idx",  int'(idx2),  mSpec[0]);
            chk("h2_arch", int'(arch2), mArch[0]);
            chk("h1_sat",  int'(sat1),  mBpt[1][mSpec[1]]);
            chk("h1_idx",  int'(idx1),  mSpec[1]);
            chk("h1_arch", int'(arch1), mArch[1]);
        end
    endtask

    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            int d, p, newArch, ix;
            d = mDepth[k];
            if (reset) begin
                mSpec[k] = 0;
                mArch[k] = 0;
                for (int i = 0; i < 4; i++) mBpt[k][i] = 0;
            end else begin
                p       = (mBpt[k][mSpec[k]] >= 2) ? 1 : 0;
                newArch = (mArch[k] * 2 + int'(updTaken)) % d;
                if (updValid) begin
                    ix = int'(updIndex) % d;
                    if (updTaken) mBpt[k][ix] = (mBpt[k][ix] == 3) ? 3 : mBpt[k][ix] + 1;
                    else          mBpt[k][ix] = (mBpt[k][ix] == 0) ? 0 : mBpt[k][ix] - 1;
                    mArch[k] = newArch;
                end
                if (updValid && updMispredict) mSpec[k] = newArch;
                else if (lookupValid && !stall) mSpec[k] = (mSpec[k] * 2 + p) % d;
            end
        end
        if (reset) modelValid = 1'b1;
    endtask

    task automatic step(input logic r, input logic st, input logic lv, input logic uv,
                        input logic [1:0] ui, input logic ut, input logic um);
        reset = r; stall = st; lookupValid = lv; updValid = uv;
        updIndex = ui; updTaken = ut; updMispredict = um;
        #1;
        checkOuts();
        @(posedge clock);
        modelEdge();
        #1;
    endtask

    task automatic train(input logic [1:0] ui, input logic ut, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, ui, ut, 0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; lookupValid = 1'b0; updValid = 1'b0;
        updIndex = 2'd0; updTaken = 1'b0; updMispredict = 1'b0;
        #2;

        // Reset state, then junk training wiped by a second reset.
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_sat", int'(sat2), 0);
        chk("rst_idx", int'(idx2), 0);
        chk("rst_arch", int'(arch2), 0);
        train(2'd0, 1, 3);
        train(2'd3, 1, 2);
        chk("junk_sat", int'(sat2), 3);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst2_sat", int'(sat2), 0);
        chk("rst2_arch", int'(arch2), 0);

        // Saturation at both ends.
        train(2'd0, 1, 2);
        chk("arch_tt", int'(arch2), 3);
        train(2'd0, 1, 2);
        chk("sat_hi", int'(sat2), 3);
        train(2'd0, 1, 1);
        chk("sat_hi_hold", int'(sat2), 3);
        train(2'd0, 0, 5);
        chk("sat_lo", int'(sat2), 0);
        chk("arch_nt", int'(arch2), 0);

        // Speculative shift: bpt[0]=3, bpt[1]=0.
        train(2'd0, 1, 3);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("shift1_idx", int'(idx2), 1);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("shift2_idx", int'(idx2), 2);

        // Stall holds the speculative history.
        step(1, 0, 0, 0, 0, 0, 0);
        train(2'd0, 1, 3);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0, 0, 0);
            chk("stall_idx", int'(idx2), 0);
        end

        // Mispredict repair wins over the same-cycle shift.
        step(1, 0, 0, 0, 0, 0, 0);
        train(2'd0, 1, 3);
        train(2'd1, 1, 3);
        train(2'd2, 0, 1);
        train(2'd2, 1, 1);
        chk("pre_arch", int'(arch2), 1);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("pre_spec", int'(idx2), 3);
        step(0, 0, 1, 1, 2'd0, 0, 1);
        chk("rep_spec", int'(idx2), 2);
        chk("rep_arch", int'(arch2), 2);

        // Same-index collision: bpt[2]=1 and spec_bhr=2 here.
        reset = 0; stall = 0; lookupValid = 0; updValid = 1; updIndex = 2'd2;
        updTaken = 1; updMispredict = 0;
        #1;
        chk("coll_now", int'(sat2), 1);
        @(posedge clock);
        modelEdge();
        #1;
        updValid = 0;
        #1;
        chk("coll_next", int'(sat2), 2);

        // One-bit history follows the last outcome.
        step(1, 0, 0, 0, 0, 0, 0);
        train(2'd0, 1, 1);
        chk("h1_arch_1", int'(arch1), 1);
        train(2'd1, 0, 1);
        chk("h1_arch_0", int'(arch1), 0);
        train(2'd0, 1, 1);
        chk("h1_arch_1b", int'(arch1), 1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(63) == 0), ($urandom_range(3) == 0), 1'($urandom),
                 1'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(3) == 0));
        end
        step(0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/bpred_history_table.md
Name: bpred_history_table

Overview:
- Two-level branch history/pattern stage that sits directly upstream of the taken/not-taken decode stage.
- It holds a global branch history register (BHR) and a pattern table (BPT) of 2-bit saturating counters.
- Each cycle it presents BPT[BHR] as sat_counter_2bit for the decode stage.
- It trains counters and history from resolved branches and repairs speculative history on mispredict.

Parameters:
- HIST_BITS, 2, BHR width; BPT depth = 2**HIST_BITS; legal range 1..8.
- INIT_CTR, 2'b00, reset value of every BPT counter.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- stall  input  1  fetch frozen; blocks speculative BHR shift.
- lookup_valid  input  1  fetch holds a branch this cycle.
- sat_counter_2bit  output  2  BPT[spec_bhr], combinational, to decode stage.
- lookup_index  output  HIST_BITS  current spec_bhr; pipelined with the branch and returned as upd_index.
- upd_valid  input  1  a branch resolved this cycle.
- upd_index  input  HIST_BITS  BPT index used when that branch was predicted.
- upd_taken  input  1  actual outcome.
- upd_mispredict  input  1  prediction was wrong; qualified by upd_valid.
- arch_bhr  output  HIST_BITS  committed history, for debug/verification.

Behaviour:
- State:
  - spec_bhr (HIST_BITS)
  - arch_bhr (HIST_BITS)
  - bpt[0 .. 2**HIST_BITS-1] (2 bits each)
- Reset:
  - Synchronous, active-high, on the clock edge with reset=1.
  - spec_bhr=0, arch_bhr=0, every bpt entry=INIT_CTR.
  - sat_counter_2bit therefore reads INIT_CTR; lookup_index=0.
  - Reset overrides all other inputs in that cycle.
  - Reset mid-operation discards in-flight history and training.
- Lookup (0-cycle latency):
  - sat_counter_2bit = bpt[spec_bhr]; lookup_index = spec_bhr.
  - Predicted direction is p = sat_counter_2bit[1], matching the decode stage: 0-1 not taken, 2-3 taken.
- Speculative shift:
  - If lookup_valid & !stall & !(upd_valid & upd_mispredict): spec_bhr <= {spec_bhr[HIST_BITS-2:0], p}, newest outcome in bit 0.
  - When HIST_BITS=1: spec_bhr <= p.
- Training (when upd_valid):
  - bpt[upd_index] increments if upd_taken, else decrements.
  - Counters saturate at 3 and at 0; no wrap.
  - arch_bhr <= {arch_bhr[HIST_BITS-2:0], upd_taken}.
- Mispredict repair (upd_valid & upd_mispredict):
  - spec_bhr <= the same new value written to arch_bhr (shifted with upd_taken).
  - Repair takes priority over a same-cycle speculative shift; that lookup's shift is dropped.
  - stall has no effect on the repair.
- Stall:
  - Gates only the speculative shift.
  - Training and repair proceed normally during a stall.
- Same-index read/write:
  - Lookup in a cycle where bpt[upd_index] is being written returns the pre-update value; there is no bypass.
  - The new value is visible the following cycle.
- upd_mispredict without upd_valid is ignored.
- No other state changes.

Test Plan:
- Reset, INIT_CTR=0, HIST_BITS=2: assert reset 1 cycle -> sat_counter_2bit=0, lookup_index=0, arch_bhr=0; preload junk via updates, reset again -> all counters read 0.
- Saturation: 4x upd_valid, upd_index=0, upd_taken=1, no lookups -> bpt[0] reaches 3 and stays 3; 5x upd_taken=0 -> reaches 0 and stays 0; arch_bhr after taken,taken = 2'b11.
- Speculative shift: bpt[0]=3, bpt[1]=0; lookup_valid for 2 cycles -> lookup_index 0 then 1; spec_bhr=2'b10 after the second edge.
- Stall: same setup with stall=1 and lookup_valid=1 for 3 cycles -> lookup_index held at 0.
- Mispredict priority: arch_bhr=2'b01, spec_bhr=2'b11. In one cycle drive lookup_valid=1, upd_valid=1, upd_mispredict=1, upd_taken=0 -> next cycle spec_bhr=arch_bhr=2'b10 and the speculative shift is dropped.
- Same-index collision: bpt[2]=1, spec_bhr=2. Drive upd_valid, upd_index=2, upd_taken=1 -> sat_counter_2bit=1 that cycle and 2 the next.
- HIST_BITS=1 build: alternate upd_taken 1,0,1 -> arch_bhr 1,0,1; lookups index only entries 0 and 1.
